// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- EX-stage integer execute unit with valid/ready on both sides.
//   Decodes alu_op/funct7/funct3 internally. Add/sub/logic/shift/compare finish
//   in one cycle; multiply/divide iterate one bit per cycle in the BUSY state.
//   Optional feature macro: ALU_EXEC_MDU_EN (M-extension mul/div/rem). With the
//   macro undefined those encodings decode as illegal and no BUSY path exists.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   flush          abort the in-flight op (wins over every other event)
//   in_valid/ready operation handshake
//   alu_op, funct7, funct3, is_word, src_a, src_b   operation and operands
//   out_valid/ready result handshake
//   result, illegal  result (0 when illegal) and undecodable-op flag
module alu_exec_unit #(
    parameter int XLEN     = 64,
    parameter int WORD_OPS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int SHW     = $clog2(XLEN);
    localparam bit WORD_EN = (XLEN == 64) && (WORD_OPS != 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic            accept, word_in;
    op_e             op_dec;
    logic [XLEN-1:0] a_s, b_s, a_z, b_z, alu_raw, alu_res;
    logic [SHW-1:0]  shamt;

    assign word_in = WORD_EN && is_word;

    // Decode. M-ops only exist when the multiply/divide unit is built.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        op_dec = OP_ILL;
        case (alu_op)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            2'b10: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000: op_dec = OP_ADD;
                            3'b001: op_dec = OP_SLL;
                            3'b010: op_dec = OP_SLT;
                            3'b011: op_dec = OP_SLTU;
                            3'b100: op_dec = OP_XOR;
                            3'b101: op_dec = OP_SRL;
                            3'b110: op_dec = OP_OR;
                            default: op_dec = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) op_dec = OP_SUB;
                        else if (funct3 == 3'b101) op_dec = OP_SRA;
                    end
`ifdef ALU_EXEC_MDU_EN
                    7'b0000001: begin
                        case (funct3)
                            3'b000: op_dec = OP_MUL;
                            3'b001: op_dec = OP_MULH;
                            3'b010: op_dec = OP_MULHSU;
                            3'b011: op_dec = OP_MULHU;
                            3'b100: op_dec = OP_DIV;
                            3'b101: op_dec = OP_DIVU;
                            3'b110: op_dec = OP_REM;
                            default: op_dec = OP_REMU;
                        endcase
                        // High-half multiplies have no word form.
                        if (word_in && funct3 inside {3'b001, 3'b010, 3'b011}) op_dec = OP_ILL;
                    end
`endif
                    default: ;
                endcase
            end
            default: begin
                // I-type: funct7[5] alone picks srai; the other bits carry shamt.
                case (funct3)
                    3'b000: op_dec = OP_ADD;
                    3'b001: op_dec = OP_SLL;
                    3'b010: op_dec = OP_SLT;
                    3'b011: op_dec = OP_SLTU;
                    3'b100: op_dec = OP_XOR;
                    3'b101: op_dec = funct7[5] ? OP_SRA : OP_SRL;
                    3'b110: op_dec = OP_OR;
                    default: op_dec = OP_AND;
                endcase
            end
        endcase
    end

    // Single-cycle datapath. Word ops use sign- or zero-extended low halves so
    // compares and right shifts see 32-bit values; the result is re-extended.
    always_comb begin
        a_s   = word_in ? sext32(src_a[31:0]) : src_a;
        b_s   = word_in ? sext32(src_b[31:0]) : src_b;
        a_z   = word_in ? XLEN'(src_a[31:0]) : src_a;
        b_z   = word_in ? XLEN'(src_b[31:0]) : src_b;
        shamt = word_in ? SHW'(src_b[4:0]) : src_b[SHW-1:0];
        case (op_dec)
            OP_ADD:  alu_raw = src_a + src_b;
            OP_SUB:  alu_raw = src_a - src_b;
            OP_SLL:  alu_raw = src_a << shamt;
            OP_SLT:  alu_raw = XLEN'($signed(a_s) < $signed(b_s));
            OP_SLTU: alu_raw = XLEN'(a_z < b_z);
            OP_XOR:  alu_raw = src_a ^ src_b;
            OP_SRL:  alu_raw = a_z >> shamt;
            OP_SRA:  alu_raw = XLEN'($signed(a_s) >>> shamt);
            OP_OR:   alu_raw = src_a | src_b;
            OP_AND:  alu_raw = src_a & src_b;
            default: alu_raw = '0;
        endcase
        alu_res = word_in ? sext32(alu_raw[31:0]) : alu_raw;
    end

`ifdef ALU_EXEC_MDU_EN
    op_e               op_q, op_d;
    logic              word_q, word_d, neg_q, neg_d, special_q, special_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d, sh_q, sh_d, opnd_q, opnd_d;
    logic              a_sgn, b_sgn, a_neg, b_neg, dec_div, special_in, busy_div, last_iter;
    logic [XLEN-1:0]   xa, xb, a_mag, b_mag, min_val, special_val;
    logic [XLEN:0]     mul_sum, div_r, div_diff;
    logic [XLEN-1:0]   acc_n, sh_n, quo, rem, mdu_res;
    logic [2*XLEN-1:0] prod;

    // Operand preparation: magnitudes for an unsigned core, plus the two
    // corner cases whose answers are fixed up front and replayed at the end.
    always_comb begin
        a_sgn   = op_dec inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_sgn   = op_dec inside {OP_MULH, OP_DIV, OP_REM};
        dec_div = op_dec inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        xa      = a_sgn ? a_s : a_z;
        xb      = b_sgn ? b_s : b_z;
        a_neg   = a_sgn && xa[XLEN-1];
        b_neg   = b_sgn && xb[XLEN-1];
        a_mag   = a_neg ? -xa : xa;
        b_mag   = b_neg ? -xb : xb;
        min_val = word_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        special_in  = 1'b0;
        special_val = '0;
        if (dec_div && xb == '0) begin
            special_in  = 1'b1;
            special_val = (op_dec inside {OP_DIV, OP_DIVU}) ? '1 : (word_in ? sext32(src_a[31:0]) : src_a);
        end else if ((op_dec inside {OP_DIV, OP_REM}) && xa == min_val && xb == '1) begin
            special_in  = 1'b1;
            special_val = (op_dec == OP_DIV) ? xa : '0;
        end
    end

    // One iteration: shift-add multiply ({acc,sh} shifts right) or restoring
    // divide ({acc,sh} shifts left, quotient bits enter at sh[0]).
    always_comb begin
        busy_div  = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        last_iter = cnt_q == (word_q ? SHW'(31) : SHW'(XLEN - 1));
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
        div_r     = {acc_q, sh_q[XLEN-1]};
        div_diff  = div_r - {1'b0, opnd_q};
        if (busy_div) begin
            acc_n = div_diff[XLEN] ? div_r[XLEN-1:0] : div_diff[XLEN-1:0];
            sh_n  = {sh_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            acc_n = mul_sum[XLEN:1];
            sh_n  = {mul_sum[0], sh_q[XLEN-1:1]};
        end
        prod = neg_q ? -{acc_n, sh_n} : {acc_n, sh_n};
        quo  = neg_q ? -sh_n : sh_n;
        rem  = neg_q ? -acc_n : acc_n;
        case (op_q)
            // A 32-iteration word multiply leaves its product in the top half of sh.
            OP_MUL:                       mdu_res = word_q ? sext32(prod[XLEN-1 -: 32]) : prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: mdu_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              mdu_res = word_q ? sext32(quo[31:0]) : quo;
            default:                      mdu_res = word_q ? sext32(rem[31:0]) : rem;
        endcase
        if (special_q) mdu_res = result_q;
    end
`endif

    // Next-state and datapath-load logic.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        accept    = in_valid && in_ready;
`ifdef ALU_EXEC_MDU_EN
        op_d = op_q; word_d = word_q; neg_d = neg_q; special_d = special_q;
        cnt_d = cnt_q; acc_d = acc_q; sh_d = sh_q; opnd_d = opnd_q;
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
`ifdef ALU_EXEC_MDU_EN
                BUSY: begin
                    acc_d = acc_n;
                    sh_d  = sh_n;
                    cnt_d = cnt_q + SHW'(1);
                    if (last_iter) begin
                        state_d  = DONE;
                        result_d = mdu_res;
                    end
                end
`endif
                DONE:    if (out_ready) state_d = IDLE;
                default: ;
            endcase
            // Acceptance is possible from IDLE or from a DONE that is draining.
            if (accept) begin
                state_d   = DONE;
                result_d  = alu_res;
                illegal_d = (op_dec == OP_ILL);
`ifdef ALU_EXEC_MDU_EN
                op_d   = op_dec;
                word_d = word_in;
                cnt_d  = '0;
                if (op_dec inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
                    state_d   = BUSY;
                    acc_d     = '0;
                    neg_d     = (op_dec inside {OP_REM, OP_REMU}) ? a_neg : (a_neg ^ b_neg);
                    special_d = special_in;
                    result_d  = special_val;
                    if (dec_div) begin
                        sh_d   = a_mag << (word_in ? XLEN - 32 : 0);
                        opnd_d = b_mag;
                    end else begin
                        sh_d   = b_mag;
                        opnd_d = a_mag;
                    end
                end
`endif
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef ALU_EXEC_MDU_EN
            op_q <= OP_ADD; word_q <= 1'b0; neg_q <= 1'b0; special_q <= 1'b0;
            cnt_q <= '0; acc_q <= '0; sh_q <= '0; opnd_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef ALU_EXEC_MDU_EN
            op_q <= op_d; word_q <= word_d; neg_q <= neg_d; special_q <= special_d;
            cnt_q <= cnt_d; acc_q <= acc_d; sh_q <= sh_d; opnd_q <= opnd_d;
`endif
        end
    end

    // Outputs.
    always_comb begin
        in_ready  = rst_n && !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
        out_valid = (state_q == DONE) && !flush;
        result    = result_q;
        illegal   = illegal_q;
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit -- directed self-checking bench for alu_exec_unit (XLEN=64).
//   Expectations for M-ops depend on whether ALU_EXEC_MDU_EN is defined.
module tb_alu_exec_unit;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, is_word, out_valid, out_ready, illegal;
    logic [1:0]      alu_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src_a, src_b, result;

    int n_checks = 0;
    int n_pass   = 0;

    alu_exec_unit #(.XLEN(XLEN), .WORD_OPS(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .is_word(is_word),
        .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    task automatic set_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic w, input logic [63:0] a, input logic [63:0] b);
        alu_op = op; funct7 = f7; funct3 = f3; is_word = w; src_a = a; src_b = b;
    endtask

    // Offer one op from IDLE, wait (bounded) for the result and drain it.
    task automatic send(input string tag, input logic [1:0] op, input logic [6:0] f7,
                        input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res,
                        input logic exp_ill, input int exp_lat);
        int cyc;
        set_op(op, f7, f3, w, a, b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " result"}, result, exp_res);
        check({tag, " illegal"}, 64'(illegal), 64'(exp_ill));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        set_op(2'b00, 7'd0, 3'd0, 1'b0, 64'd1, 64'd2);

        // Reset held two cycles with an op offered.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("reset out_valid", 64'(out_valid), 64'd0);
            check("reset result", result, 64'd0);
            check("reset in_ready", 64'(in_ready), 64'd0);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single-cycle ops.
        send("r-sub",   2'b10, 7'b0100000, 3'b000, 1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1);
        send("add-wrap",2'b00, 7'b0000000, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1);
        send("sraw",    2'b10, 7'b0100000, 3'b101, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1'b0, 1);
        send("slt",     2'b10, 7'b0000000, 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1);
        send("sltu",    2'b10, 7'b0000000, 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1);
        send("srai63",  2'b11, 7'b0100001, 3'b101, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
        send("addw-ovf",2'b10, 7'b0000000, 3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1);
        send("sllw",    2'b10, 7'b0000000, 3'b001, 1'b1, 64'd1, 64'd33, 64'd2, 1'b0, 1);
        send("sll",     2'b10, 7'b0000000, 3'b001, 1'b0, 64'd1, 64'd33, 64'h0000_0002_0000_0000, 1'b0, 1);
        send("xori",    2'b11, 7'b0000000, 3'b100, 1'b0, 64'hF0F0, 64'h0FF0, 64'hFF00, 1'b0, 1);
        send("bad-f7",  2'b10, 7'b0000010, 3'b000, 1'b0, 64'd9, 64'd9, 64'd0, 1'b1, 1);

`ifdef ALU_EXEC_MDU_EN
        send("div0",    2'b10, 7'b0000001, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65);
        send("div",     2'b10, 7'b0000001, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 65);
        send("rem",     2'b10, 7'b0000001, 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65);
        send("div-ovf", 2'b10, 7'b0000001, 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 65);
        send("mulhu",   2'b10, 7'b0000001, 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65);
        send("mulw",    2'b10, 7'b0000001, 3'b000, 1'b1, 64'h0001_0000, 64'h0001_0003, 64'h0000_0000_0003_0000, 1'b0, 33);
`else
        send("div0",    2'b10, 7'b0000001, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 64'd0, 1'b1, 1);
`endif

        // Backpressure: result held, next op waits, then is taken on the drain cycle.
        set_op(2'b10, 7'b0000000, 3'b110, 1'b0, 64'h0F, 64'hF0);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        set_op(2'b10, 7'b0000000, 3'b111, 1'b0, 64'hFF, 64'h3C);
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp result", result, 64'hFF);
            check("bp in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp drain in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp next out_valid", 64'(out_valid), 64'd1);
        check("bp next result", result, 64'h3C);
        @(posedge clk); #1;

        // Flush of an in-flight op: nothing is delivered, a fresh op runs cleanly.
`ifdef ALU_EXEC_MDU_EN
        set_op(2'b10, 7'b0000001, 3'b000, 1'b0, 64'h1234, 64'h5678);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
`else
        set_op(2'b10, 7'b0000000, 3'b100, 1'b0, 64'h3, 64'h5);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        check("flush pre out_valid", 64'(out_valid), 64'd1);
`endif
        flush = 1'b1; in_valid = 1'b1;
        #1;
        check("flush in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush idle in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush no late result", 64'(seen), 64'd0);
`ifdef ALU_EXEC_MDU_EN
        send("mul3x4", 2'b10, 7'b0000001, 3'b000, 1'b0, 64'd3, 64'd4, 64'd12, 1'b0, 65);
`else
        send("mul3x4", 2'b10, 7'b0000001, 3'b000, 1'b0, 64'd3, 64'd4, 64'd0, 1'b1, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Accepts one operation per handshake and decodes alu_op/funct7/funct3 internally.
- Single-cycle ops (add/sub/logic/shift/compare) complete in one cycle; multiply/divide run iteratively over several cycles.
- Sits in the EX stage between the ID/EX register and the writeback path, with valid/ready on both sides.

Parameters:
- XLEN, 64, datapath width (32 or 64).
- WORD_OPS, 1, enables is_word (RV64 *W) handling; ignored when XLEN=32.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- flush  in  1  synchronous abort of the in-flight op
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept
- alu_op  in  2  00 add, 01 sub, 10 R-type, 11 I-type
- funct7  in  7  instruction funct7
- funct3  in  3  instruction funct3
- is_word  in  1  32-bit op, result sign-extended to XLEN
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B or immediate
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result
- illegal  out  1  undecodable op; result is 0

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; in_ready=0 during reset, 1 the cycle after; out_valid=0; result=0; illegal=0; iteration counter=0.
- FSM states: IDLE, BUSY (mul/div iterating), DONE (holding result).
- IDLE, in_valid && in_ready && !flush: latch operands/decode.
  - Single-cycle op: go to DONE; out_valid=1 on the next cycle (latency 1).
  - Mul/div: go to BUSY.
- BUSY runs N iterations, N=32 if word op else XLEN (radix-2 shift-add multiply, restoring divide). DONE follows the last iteration, so out_valid rises N+1 cycles after acceptance.
- DONE: result/illegal held stable while out_valid && !out_ready.
  - out_ready=1: completes the transfer.
  - If in_valid is also 1, the new op is accepted the same cycle (in_ready = IDLE || (DONE && out_ready)).
  - Otherwise return to IDLE.
- in_ready=0 in BUSY and whenever flush=1.
- flush=1: next state IDLE, out_valid=0, no input accepted; flush wins over every simultaneous event.
- Decode:
  - alu_op 00 → add; 01 → sub.
  - alu_op 10 → {funct7,funct3}: 0000000_000 add; 0100000_000 sub; 0000000_001 sll; 0000000_010 slt; 0000000_011 sltu; 0000000_100 xor; 0000000_101 srl; 0100000_101 sra; 0000000_110 or; 0000000_111 and; 0000001_xxx M-ops (see Optional Feature). Anything else → illegal.
  - alu_op 11 → funct3 selects addi/slti/sltiu/xori/ori/andi. Shifts use funct7[5] for srai, with funct7[6:1] ignored for XLEN=64 imm bit 5.
- Shifts: shamt = src_b[log2(XLEN)-1:0], or src_b[4:0] when is_word.
- Word mode: operate on low 32 bits, then sign-extend bit 31. is_word is ignored (treated as 0) when XLEN=32 or WORD_OPS=0.
- Add/sub wrap modulo 2^width. slt is signed, sltu unsigned; result is 0 or 1.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (min / -1): quotient = dividend, remainder = 0.
- Illegal op: one-cycle path, result=0, illegal=1.

Optional Feature:
- Macro ALU_EXEC_MDU_EN.
- Defined:
  - funct7=0000001 under alu_op 10 decodes mul, mulh, mulhsu, mulhu, div, divu, rem, remu by funct3, using the BUSY path.
  - Word variants are supported for mul/div/divu/rem/remu.
- Undefined:
  - Those encodings return illegal=1, result=0 with latency 1.
  - BUSY state and iterative datapath are not synthesised.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, result=0; in_ready=1 the first cycle after release.
- R-type sub, XLEN=64: src_a=5, src_b=7, funct7=0100000, funct3=000 → one cycle later result=0xFFFF_FFFF_FFFF_FFFE, illegal=0.
- Word sra: is_word=1, src_a=0x0000_0000_8000_0000, src_b=4 → result=0xFFFF_FFFF_F800_0000.
- MDU divide by zero (macro defined): div src_a=-9, src_b=0 → out_valid 65 cycles after accept with result=0xFFFF_FFFF_FFFF_FFFF. Same with the macro undefined → illegal=1 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles → result stable, in_ready=0. Raise out_ready with in_valid=1 → next op accepted the same cycle.
- Flush asserted mid-BUSY (cycle 10 of mul) → IDLE next cycle, out_valid never asserts for that op; next mul 3×4 returns 12.
